ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard or mouse, such as 0xED (set LEDs) and 0xF4 (enable reporting). It shares the open-drain ps2c/ps2d lines with ps2_rx and drives only low-enables; the top level builds the tri-states. While tx_idle is low, the top level must hold ps2_rx.rx_en low so the receiver ignores the transmit exchange.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_clk_filter.sv | 38 +++
 rtl/ps2_tx.sv | 132 +++++++++++++
 tb/tb_ps2_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame layout and common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    WAIT_REL
  } state_t;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  // Transmit order is LSB first: start, data0..data7, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {STOP_BIT, ~^b, b, START_BIT};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the PS/2 clock pad: the filtered level only moves once eight
// consecutive samples agree; neg_edge flags the cycle the filtered level falls.
module ps2_clk_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic ps2c_in,
  output logic f_val,
  output logic neg_edge
);

  logic [7:0] filter_q, filter_d;
  logic       f_val_q, f_val_d;

  always_comb begin
    filter_d = {ps2c_in, filter_q[7:1]};
    f_val_d  = f_val_q;
    if (filter_d == 8'hFF)
      f_val_d = 1'b1;
    else if (filter_d == 8'h00)
      f_val_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filter_q <= 8'h00;
      f_val_q  <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_val_q  <= f_val_d;
    end
  end

  assign f_val    = f_val_q;
  assign neg_edge = f_val_q & ~f_val_d;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit/request-to-send, clocked-out frame,
// ack check and a watchdog over the whole device-clocked phase.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int             CW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  INHIBIT_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   d_reg_q, d_reg_d;
  logic [3:0]              n_q, n_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    ps2d_meta_q, ps2d_s_q;
  logic                    f_val, neg_edge;

  ps2_clk_filter u_clk_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2c_in  (ps2c_in),
    .f_val    (f_val),
    .neg_edge (neg_edge)
  );

  always_comb begin
    state_d = state_q;
    d_reg_d = d_reg_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ps2) begin
          d_reg_d = build_frame(din);
          cnt_d   = INHIBIT_LOAD;
          state_d = RTS;
        end
      end
      RTS: begin
        if (cnt_q == '0) begin
          n_d     = 4'd10;
          state_d = START;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      START, DATA, WAIT_REL: begin
        cnt_d = cnt_q + CW'(1);
        // Watchdog wins over any bus activity in the same cycle.
        if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (state_q == WAIT_REL) begin
          if (f_val && ps2d_s_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (neg_edge) begin
          if (n_q != 4'd0) begin
            d_reg_d = {1'b1, d_reg_q[FRAME_BITS-1:1]};
            n_d     = n_q - 4'd1;
            state_d = DATA;
          end else if (!ps2d_s_q) begin
            state_d = WAIT_REL;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      d_reg_q     <= '0;
      n_q         <= 4'd0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ps2d_meta_q <= 1'b0;
      ps2d_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_reg_q     <= d_reg_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ps2d_meta_q <= ps2d_in;
      ps2d_s_q    <= ps2d_meta_q;
    end
  end

  // Line enables decode straight from the state so reset releases them at once.
  always_comb begin
    ps2c_oe = 1'b0;
    ps2d_oe = 1'b0;
    case (state_q)
      RTS:     ps2c_oe = 1'b1;
      START:   ps2d_oe = 1'b1;
      DATA:    ps2d_oe = ~d_reg_q[0];
      default: ;
    endcase
  end

  assign tx_idle      = (state_q == IDLE);
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a device model clocks the frame out of the open-drain lines,
// frames and completion ticks are scored against queued expectations.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 2000;
  localparam int M_ACK = 0, M_NACK = 1, M_NOCLK = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;
  logic       bfm_c_low = 1'b0, bfm_d_low = 1'b0;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = ~(ps2c_oe | bfm_c_low);
  assign ps2d_line = ~(ps2d_oe | bfm_d_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2c_in      (ps2c_line),
    .ps2d_in      (ps2d_line),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int lat;
  } evt_t;

  evt_t        evt_q[$];
  logic [10:0] frame_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          bfm_mode = M_ACK;
  int          bfm_bits = 0;
  bit          bfm_abort = 1'b0;
  bit          bfm_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference frame from the protocol rules: odd parity means the 9 bits hold an odd count of ones.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic expect_tx(input logic [7:0] b, input bit is_err, input int lat);
    evt_t e;
    if (bfm_mode != M_NOCLK) frame_q.push_back(model_frame(b));
    e.is_err = is_err;
    e.lat    = lat;
    evt_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_idle && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("idle_before_send", 0, 1);
    @(negedge clk);
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((evt_q.size() != 0 || bfm_busy || !tx_idle) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completed"}, int'(n < 6000), 1);
    wait_cycles(100);
  endtask

  // Device model: waits for request-to-send, then clocks start..stop and the ack bit.
  initial begin
    logic [10:0] rx;
    logic [10:0] exp_f;
    forever begin
      @(negedge clk);
      if (!ps2c_oe || !reset_n) continue;
      bfm_busy = 1'b1;
      bfm_bits = 0;
      while (ps2c_oe) @(negedge clk);
      if (bfm_mode == M_NOCLK || bfm_abort) begin
        bfm_busy = 1'b0;
        continue;
      end
      wait_cycles(50);
      rx[0]    = ps2d_line;
      bfm_bits = 1;
      for (int k = 0; k < 10 && !bfm_abort; k++) begin
        bfm_c_low = 1'b1;
        wait_cycles(40);
        bfm_c_low = 1'b0;
        wait_cycles(20);
        rx[k+1] = ps2d_line;
        bfm_bits++;
        wait_cycles(20);
      end
      if (!bfm_abort) begin
        if (bfm_mode == M_ACK) begin
          bfm_d_low = 1'b1;
          wait_cycles(20);
        end
        bfm_c_low = 1'b1;
        wait_cycles(40);
        bfm_c_low = 1'b0;
        wait_cycles(10);
        bfm_d_low = 1'b0;
        if (frame_q.size() == 0) begin
          chk("frame_expected", 0, 1);
        end else begin
          exp_f = frame_q.pop_front();
          chk("frame_bits", int'(rx), int'(exp_f));
        end
      end
      bfm_c_low = 1'b0;
      bfm_d_low = 1'b0;
      bfm_busy  = 1'b0;
    end
  end

  // Request-to-send length, start bit hand-over and the timestamp of START entry.
  initial begin
    int  len = 0;
    bit  prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        len  = 0;
        prev = 1'b0;
      end else begin
        if (ps2c_oe) begin
          len++;
        end else if (prev) begin
          chk("rts_len", len, INH);
          chk("start_bit_driven", int'(ps2d_oe), 1);
          start_cyc = cyc;
          len = 0;
        end
        prev = ps2c_oe;
      end
    end
  end

  // Completion monitor: every tick must match the oldest queued expectation.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (reset_n && tx_idle) chk("idle_d_released", int'(ps2d_oe), 0);
      if (reset_n && (tx_done_tick || tx_err_tick)) begin
        if (evt_q.size() == 0) begin
          chk("unexpected_tick", int'({tx_done_tick, tx_err_tick}), 0);
        end else begin
          e = evt_q.pop_front();
          chk("tick_kind", int'({tx_done_tick, tx_err_tick}), e.is_err ? 1 : 2);
          chk("tick_idle", int'(tx_idle), 1);
          chk("tick_lines", int'({ps2c_oe, ps2d_oe}), 0);
          if (e.lat >= 0) chk("timeout_latency", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int n;
    wait_cycles(5);
    chk("rst_idle", int'(tx_idle), 1);
    chk("rst_c_oe", int'(ps2c_oe), 0);
    chk("rst_d_oe", int'(ps2d_oe), 0);
    chk("rst_done", int'(tx_done_tick), 0);
    chk("rst_err", int'(tx_err_tick), 0);
    reset_n = 1'b1;
    wait_cycles(20);

    bfm_mode = M_ACK;
    expect_tx(CMD_SET_LED, 1'b0, -1);
    send(CMD_SET_LED);
    wait_done("set_led");

    expect_tx(CMD_ENABLE, 1'b0, -1);
    send(CMD_ENABLE);
    wait_done("enable");

    expect_tx(8'h00, 1'b0, -1);
    send(8'h00);
    wait_done("zero");

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      expect_tx(b, 1'b0, -1);
      send(b);
      wait_done("random");
    end

    bfm_mode = M_NOCLK;
    expect_tx(8'h55, 1'b1, TMO);
    send(8'h55);
    wait_done("timeout");

    bfm_mode = M_NACK;
    expect_tx(8'hA6, 1'b1, -1);
    send(8'hA6);
    wait_done("nack");
    chk("nack_d_released", int'(ps2d_oe), 0);

    bfm_mode = M_ACK;
    expect_tx(CMD_ENABLE, 1'b0, -1);
    send(CMD_ENABLE);
    wait_cycles(300);
    chk("busy_mid_frame", int'(tx_idle), 0);
    wr_ps2 = 1'b1;
    din    = 8'h00;
    @(negedge clk);
    wr_ps2 = 1'b0;
    wait_done("ignored_wr");

    send(CMD_SET_LED);
    n = 0;
    while (bfm_bits < 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit4", int'(n < 3000), 1);
    wait_cycles(55);
    chk("pre_reset_d_oe", int'(ps2d_oe), 1);
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    bfm_abort = 1'b1;
    #1;
    chk("async_rst_c_oe", int'(ps2c_oe), 0);
    chk("async_rst_d_oe", int'(ps2d_oe), 0);
    wait_cycles(3);
    chk("rst_mid_idle", int'(tx_idle), 1);
    chk("rst_mid_ticks", int'({tx_done_tick, tx_err_tick}), 0);
    reset_n = 1'b1;
    n = 0;
    while (bfm_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("bfm_aborted", int'(bfm_busy), 0);
    bfm_abort = 1'b0;
    wait_cycles(20);
    chk("post_rst_idle", int'(tx_idle), 1);
    expect_tx(CMD_SET_LED, 1'b0, -1);
    send(CMD_SET_LED);
    wait_done("after_reset");

    chk("queues_empty", evt_q.size() + frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
